// File: rtl/flag_cond_unit.sv
// rtl/flag_cond_unit.sv - EX-stage N/Z/C/V flag register and B.cond evaluator
// Optional same-cycle flag forwarding to branches: FLAG_BYPASS_EN
module flag_cond_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ex_valid,
    input  logic             ex_set_flags,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             stall,
    input  logic             flush,
    input  logic             br_valid,
    input  logic [3:0]       br_cond,
    output logic [3:0]       flags_q,
    output logic             br_stall,
    output logic             br_resolved,
    output logic             br_taken
);

    logic [3:0]  r_flags;
    logic        r_br_resolved;
    logic        r_br_taken;

    logic [15:0] w_nib_zero;
    logic [3:0]  w_grp_zero;
    logic        w_z;
    logic [3:0]  w_next_flags;
    logic        w_upd;
    logic        w_acc;
    logic [3:0]  w_eval_flags;
    logic        w_n, w_zf, w_c, w_v;
    logic        w_cond_true;

    // Zero detect mirrors the datapath tree: 16 nibble NORs, 4 group ANDs, final AND
    for (genvar i = 0; i < 16; i++) begin : g_nib
        assign w_nib_zero[i] = ~|alu_result[4*i +: 4];
    end
    for (genvar g = 0; g < 4; g++) begin : g_grp
        assign w_grp_zero[g] = &w_nib_zero[4*g +: 4];
    end
    assign w_z = &w_grp_zero;

    assign w_next_flags = {alu_result[WIDTH-1], w_z, alu_carry, alu_overflow};
    assign w_upd        = ex_valid & ex_set_flags & ~stall & ~flush;

`ifdef FLAG_BYPASS_EN
    assign br_stall     = 1'b0;
    assign w_eval_flags = w_upd ? w_next_flags : r_flags;
`else
    // Hold a colliding branch one cycle so it sees the freshly written flags_q
    assign br_stall     = br_valid & w_upd;
    assign w_eval_flags = r_flags;
`endif

    assign w_acc = br_valid & ~stall & ~flush & ~br_stall;
    assign {w_n, w_zf, w_c, w_v} = w_eval_flags;

    always_comb begin
        w_cond_true = 1'b1;
        case (br_cond[3:1])
            3'b000:  w_cond_true = w_zf;
            3'b001:  w_cond_true = w_c;
            3'b010:  w_cond_true = w_n;
            3'b011:  w_cond_true = w_v;
            3'b100:  w_cond_true = w_c & ~w_zf;
            3'b101:  w_cond_true = (w_n == w_v);
            3'b110:  w_cond_true = ~w_zf & (w_n == w_v);
            default: w_cond_true = 1'b1;
        endcase
        // Odd codes invert, except 1111 which is always taken
        if (br_cond[0] && (br_cond[3:1] != 3'b111)) begin
            w_cond_true = ~w_cond_true;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flags       <= 4'b0000;
            r_br_resolved <= 1'b0;
            r_br_taken    <= 1'b0;
        end else begin
            if (w_upd) begin
                r_flags <= w_next_flags;
            end
            r_br_resolved <= w_acc;
            if (w_acc) begin
                r_br_taken <= w_cond_true;
            end
        end
    end

    assign flags_q     = r_flags;
    assign br_resolved = r_br_resolved;
    assign br_taken    = r_br_taken;

endmodule
